// File: rtl/gbr_route_pkg.sv
// Shared route geometry for the GA tour datapath: packer, distance evaluator and population memory.
package gbr_route_pkg;

  localparam int N_CITIES = 30;
  localparam int CITY_W   = 5;
  localparam int ROUTE_W  = N_CITIES * CITY_W;

  typedef logic [CITY_W-1:0]  city_t;
  typedef logic [ROUTE_W-1:0] route_t;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } pack_state_t;

endpackage

// File: rtl/route_perm_check.sv
// Seen-bitmap permutation checker for one route; sticky error on a duplicate or out-of-range city.
// Built only when ROUTE_PACK_PERM_CHECK_EN is defined.
`ifdef ROUTE_PACK_PERM_CHECK_EN
module route_perm_check
  import gbr_route_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  clr,
  input  logic  accept,
  input  city_t city,
  output logic  err
);

  logic [N_CITIES-1:0] seen;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      seen <= '0;
      err  <= 1'b0;
    end else if (accept) begin
      // Range check first so the bitmap is never indexed past its top city.
      if (city >= CITY_W'(N_CITIES)) begin
        err <= 1'b1;
      end else if (seen[city]) begin
        err <= 1'b1;
      end else begin
        seen[city] <= 1'b1;
      end
    end
  end

endmodule
`endif

// File: rtl/route_packer.sv
// Serial-to-parallel packer: 30 city indices in, one 150-bit route out, with optional permutation check.
// Optional checker enabled by defining ROUTE_PACK_PERM_CHECK_EN; otherwise out_error is tied low.
module route_packer
  import gbr_route_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CITY_W-1:0]  in_city,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ROUTE_W-1:0] out_route,
  output logic               out_error,
  output logic [4:0]         fill_count
);

  pack_state_t state;
  logic        accept;
  logic        chk_clr;

  // Flush beats a coincident handshake, and is ignored once the route is complete.
  assign accept  = (state == FILL) && in_valid && !flush;
  assign chk_clr = ((state == FILL) && flush) || ((state == HOLD) && out_ready);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= FILL;
      fill_count <= '0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      out_route  <= '0;
    end else begin
      case (state)
        FILL: begin
          if (flush) begin
            fill_count <= '0;
          end else if (in_valid) begin
            for (int k = 0; k < N_CITIES; k++) begin
              if (fill_count == 5'(k)) begin
                out_route[k*CITY_W +: CITY_W] <= in_city;
              end
            end
            if (fill_count == 5'(N_CITIES - 1)) begin
              fill_count <= '0;
              state      <= HOLD;
              in_ready   <= 1'b0;
              out_valid  <= 1'b1;
            end else begin
              fill_count <= fill_count + 5'd1;
            end
          end
        end
        HOLD: begin
          // No bypass: the handshake edge only reopens the input for the next cycle.
          if (out_ready) begin
            state     <= FILL;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state <= FILL;
        end
      endcase
    end
  end

`ifdef ROUTE_PACK_PERM_CHECK_EN
  route_perm_check u_perm_check (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (chk_clr),
    .accept (accept),
    .city   (in_city),
    .err    (out_error)
  );
`else
  logic unused_chk;
  assign unused_chk = accept ^ chk_clr;
  assign out_error  = 1'b0;
`endif

endmodule

// File: tb/tb_route_packer.sv
// Bench for route_packer: directed test-plan routes plus randomized routes against a route-level model.
module tb_route_packer;
  import gbr_route_pkg::*;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               flush;
  logic               in_valid;
  logic               in_ready;
  logic [CITY_W-1:0]  in_city;
  logic               out_valid;
  logic               out_ready;
  logic [ROUTE_W-1:0] out_route;
  logic               out_error;
  logic [4:0]         fill_count;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [4:0] cur [N_CITIES];
  int acc_cyc [60];

  route_packer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_city    (in_city),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_route  (out_route),
    .out_error  (out_error),
    .fill_count (fill_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_cnt(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_route(input string tag, input route_t obs, input route_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic route_t pack_route();
    route_t r = '0;
    for (int k = 0; k < N_CITIES; k++) r[k*CITY_W +: CITY_W] = cur[k];
    return r;
  endfunction

  function automatic logic exp_error();
`ifdef ROUTE_PACK_PERM_CHECK_EN
    int cnt [32];
    logic e = 1'b0;
    for (int k = 0; k < 32; k++) cnt[k] = 0;
    for (int k = 0; k < N_CITIES; k++) begin
      if (cur[k] >= 5'd30 || cnt[cur[k]] != 0) e = 1'b1;
      cnt[cur[k]]++;
    end
    return e;
`else
    return 1'b0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk_bit({tag, "_out_valid"}, out_valid, 1'b0);
    chk_bit({tag, "_in_ready"}, in_ready, 1'b1);
    chk_cnt({tag, "_fill_count"}, fill_count, 5'd0);
    chk_route({tag, "_out_route"}, out_route, '0);
    chk_bit({tag, "_out_error"}, out_error, 1'b0);
  endtask

  task automatic send_city(input logic [4:0] c);
    int guard = 0;
    logic acc;
    in_valid = 1'b1;
    in_city  = c;
    do begin
      acc = in_ready;
      tick();
      guard++;
    end while (!acc && guard < 100);
    in_valid = 1'b0;
    in_city  = 5'($urandom);
    if (!acc) chk_bit("accept_timeout", acc, 1'b1);
  endtask

  task automatic fill_route(input int bubble_max);
    for (int i = 0; i < N_CITIES; i++) begin
      repeat ($urandom_range(bubble_max, 0)) tick();
      send_city(cur[i]);
      if (i < N_CITIES - 1) chk_cnt("fill_count", fill_count, 5'(i + 1));
    end
    chk_bit("out_valid_rise", out_valid, 1'b1);
    chk_bit("in_ready_hold", in_ready, 1'b0);
    chk_route("out_route", out_route, pack_route());
    chk_bit("out_error", out_error, exp_error());
    chk_cnt("fill_wrap", fill_count, 5'd0);
  endtask

  // Stall in HOLD with a city pending and a stray flush, then hand the route off.
  task automatic drain(input int stall);
    route_t er = pack_route();
    in_valid  = 1'b1;
    in_city   = 5'd3;
    out_ready = 1'b0;
    for (int s = 0; s < stall; s++) begin
      flush = (s == stall / 2);
      tick();
      flush = 1'b0;
      chk_bit("stall_out_valid", out_valid, 1'b1);
      chk_route("stall_out_route", out_route, er);
      chk_bit("stall_in_ready", in_ready, 1'b0);
      chk_bit("stall_out_error", out_error, exp_error());
    end
    out_ready = 1'b1;
    chk_bit("handshake_in_ready", in_ready, 1'b0);
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk_bit("after_hs_out_valid", out_valid, 1'b0);
    chk_bit("after_hs_in_ready", in_ready, 1'b1);
    chk_cnt("after_hs_no_accept", fill_count, 5'd0);
  endtask

  task automatic shuffle();
    for (int i = 0; i < N_CITIES; i++) cur[i] = 5'(i);
    for (int i = N_CITIES - 1; i > 0; i--) begin
      int j = $urandom_range(i, 0);
      logic [4:0] t = cur[i];
      cur[i] = cur[j];
      cur[j] = t;
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_city   = '0;
    out_ready = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    chk_reset_state("reset");

    // Identity routes streamed back-to-back with out_ready held high.
    begin
      int idx = 0;
      int guard = 0;
      logic acc;
      for (int i = 0; i < N_CITIES; i++) cur[i] = 5'(i);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_city   = 5'd0;
      while (idx < 60 && guard < 200) begin
        acc = in_ready;
        tick();
        guard++;
        if (acc) begin
          acc_cyc[idx] = cyc;
          idx++;
          in_city = 5'(idx % N_CITIES);
          if (idx == 30 || idx == 60) begin
            chk_bit("id_out_valid", out_valid, 1'b1);
            chk_bit("id_in_ready", in_ready, 1'b0);
            chk_route("id_route", out_route, pack_route());
            chk_cnt("id_slot0", out_route[4:0], 5'd0);
            chk_cnt("id_slot29", out_route[149:145], 5'd29);
            chk_bit("id_error", out_error, 1'b0);
          end
        end
      end
      chk_bit("id_stream_done", idx == 60, 1'b1);
      if (idx == 60) chk_bit("id_31_cycle", (acc_cyc[30] - acc_cyc[0]) == 31, 1'b1);
      in_valid = 1'b0;
      tick();
      out_ready = 1'b0;
      chk_bit("id_drained", out_valid, 1'b0);
    end

    // Reversed route with a 10-cycle downstream stall.
    for (int i = 0; i < N_CITIES; i++) cur[i] = 5'(N_CITIES - 1 - i);
    fill_route(0);
    drain(10);

    // Duplicate city in the last slot.
    for (int i = 0; i < N_CITIES - 1; i++) cur[i] = 5'(i);
    cur[N_CITIES - 1] = 5'd5;
    fill_route(1);
    drain(2);

    // Out-of-range city in slot 7.
    for (int i = 0; i < N_CITIES; i++) cur[i] = 5'(i);
    cur[7] = 5'd31;
    fill_route(0);
    chk_cnt("oor_slot7", out_route[39:35], 5'd31);
    drain(1);

    // Flush mid-fill: twelve cities (with a duplicate), then flush against a valid 13th.
    for (int i = 0; i < 12; i++) send_city(i == 0 ? 5'd0 : 5'(i - 1));
    chk_cnt("pre_flush_count", fill_count, 5'd12);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_city  = 5'd12;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk_cnt("flush_count", fill_count, 5'd0);
    for (int i = 0; i < N_CITIES; i++) cur[i] = 5'(i);
    fill_route(0);
    drain(0);

    // Randomized routes: clean permutations, duplicates and out-of-range cities.
    for (int r = 0; r < 6; r++) begin
      int mode = $urandom_range(2, 0);
      int a = $urandom_range(N_CITIES - 1, 0);
      shuffle();
      if (mode == 1) cur[a] = cur[(a + 1 + $urandom_range(N_CITIES - 2, 0)) % N_CITIES];
      if (mode == 2) cur[a] = 5'($urandom_range(31, 30));
      fill_route(2);
      drain($urandom_range(4, 0));
    end

    // Reset mid-fill.
    for (int i = 0; i < 9; i++) send_city(5'd4);
    do_reset();
    chk_reset_state("rst_fill");

    // Reset mid-HOLD.
    shuffle();
    cur[0] = 5'd31;
    fill_route(0);
    do_reset();
    chk_reset_state("rst_hold");

    // After reset, a fresh route still packs correctly.
    shuffle();
    fill_route(1);
    drain(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
